// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        RESP
    } state_t;

    // Byte-offset bits inside a 32-bit word.
    localparam int unsigned OFF_W = 2;

    function automatic int unsigned widx_w(input int unsigned words);
        return $clog2(words);
    endfunction

    function automatic int unsigned idx_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned tag_w(input int unsigned addr_w,
                                          input int unsigned lines,
                                          input int unsigned words);
        return addr_w - idx_w(lines) - widx_w(words) - OFF_W;
    endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-side and memory-side handshake bundle for icache_dm.
// slave: the cache; master: the fetch stage / memory controller pair driving it.
interface icache_dm_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [31:0]       resp_inst;
    logic              flush;
    logic              mem_rn;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [31:0]       mem_value;

    modport slave (
        input  req_valid, req_addr, flush, mem_ready, mem_value,
        output req_ready, resp_valid, resp_inst, mem_rn, mem_addr
    );

    modport master (
        output req_valid, req_addr, flush, mem_ready, mem_value,
        input  req_ready, resp_valid, resp_inst, mem_rn, mem_addr
    );
endinterface

// File: rtl/icache_tag_array.sv
// Valid bits and tags for the direct-mapped cache: whole-array flush, per-line write,
// combinational hit compare on the read port.
module icache_tag_array
    import icache_pkg::*;
#(
    parameter int unsigned LINES = 32,
    parameter int unsigned TAG_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     flush_all,
    input  logic [idx_w(LINES)-1:0]  rd_idx,
    input  logic [TAG_W-1:0]         rd_tag,
    output logic                     hit,
    input  logic                     wr_en,
    input  logic [idx_w(LINES)-1:0]  wr_idx,
    input  logic [TAG_W-1:0]         wr_tag,
    input  logic                     wr_valid
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [LINES];

    // Valid bits: cleared by reset or flush, otherwise updated by line writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (en) begin
            if (flush_all) begin
                valid_q <= '0;
            end else if (wr_en) begin
                valid_q[wr_idx] <= wr_valid;
            end
        end
    end

    // Tag storage needs no reset; a line is only trusted through its valid bit.
    always_ff @(posedge clk) begin
        if (!rst && en && wr_en) begin
            tag_q[wr_idx] <= wr_tag;
        end
    end

    assign hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: one-cycle hits, whole-line refill one word per
// mem_ready pulse, single-cycle flush. Global rdy freezes everything.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined; otherwise
// hit_cnt/miss_cnt are tied to zero.
module icache_dm
    import icache_pkg::*;
#(
    parameter int unsigned LINES  = 32,
    parameter int unsigned WORDS  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    icache_dm_if.slave  bus,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int unsigned WIDX_W  = widx_w(WORDS);
    localparam int unsigned IDX_W   = idx_w(LINES);
    localparam int unsigned TAG_W   = tag_w(ADDR_W, LINES, WORDS);
    localparam int unsigned IDX_LSB = OFF_W + WIDX_W;
    localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;
    localparam int unsigned DEPTH   = LINES * WORDS;

    // Request address split.
    logic [WIDX_W-1:0] req_widx;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [ADDR_W-1:0] req_base;
    logic              unused_byte_bits;

    assign req_widx         = bus.req_addr[IDX_LSB-1:OFF_W];
    assign req_idx          = bus.req_addr[TAG_LSB-1:IDX_LSB];
    assign req_tag          = bus.req_addr[ADDR_W-1:TAG_LSB];
    assign req_base         = {bus.req_addr[ADDR_W-1:IDX_LSB], {IDX_LSB{1'b0}}};
    assign unused_byte_bits = ^bus.req_addr[OFF_W-1:0];

    // Registered state and outputs.
    state_t            state_q;
    logic [WIDX_W-1:0] lat_widx_q;
    logic [IDX_W-1:0]  lat_idx_q;
    logic [TAG_W-1:0]  lat_tag_q;
    logic [WIDX_W-1:0] word_cnt_q;
    logic              flush_seen_q;
    logic              resp_valid_q;
    logic [31:0]       resp_inst_q;
    logic              mem_rn_q;
    logic [ADDR_W-1:0] mem_addr_q;

    logic [31:0] data_mem [DEPTH];
    logic [31:0] hit_word;
    logic [31:0] lat_word;
    logic        hit;
    logic        accept;
    logic        refill_beat;
    logic        last_word;
    logic        tag_wr_en;
    logic        tag_wr_valid;
    logic        tag_flush_all;

    assign bus.req_ready  = !rst && (state_q == IDLE) && !bus.flush;
    assign accept         = bus.req_valid && bus.req_ready && rdy;
    assign refill_beat    = (state_q == REFILL) && bus.mem_ready;
    assign last_word      = (word_cnt_q == WIDX_W'(WORDS - 1));

    assign hit_word       = data_mem[{req_idx, req_widx}];
    assign lat_word       = data_mem[{lat_idx_q, lat_widx_q}];

    // A flush seen anywhere in the refill, or during RESP, leaves the new line invalid.
    assign tag_wr_en      = (refill_beat && last_word) || ((state_q == RESP) && bus.flush);
    assign tag_wr_valid   = (state_q == REFILL) && !flush_seen_q && !bus.flush;
    assign tag_flush_all  = (state_q == IDLE) && bus.flush;

    icache_tag_array #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_tags (
        .clk       (clk),
        .rst       (rst),
        .en        (rdy),
        .flush_all (tag_flush_all),
        .rd_idx    (req_idx),
        .rd_tag    (req_tag),
        .hit       (hit),
        .wr_en     (tag_wr_en),
        .wr_idx    (lat_idx_q),
        .wr_tag    (lat_tag_q),
        .wr_valid  (tag_wr_valid)
    );

    // Data array: refill beats write word k of the latched line.
    always_ff @(posedge clk) begin
        if (!rst && rdy && refill_beat) begin
            data_mem[{lat_idx_q, word_cnt_q}] <= bus.mem_value;
        end
    end

    // Control FSM with registered response and memory-request outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lat_widx_q   <= '0;
            lat_idx_q    <= '0;
            lat_tag_q    <= '0;
            word_cnt_q   <= '0;
            flush_seen_q <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_inst_q  <= '0;
            mem_rn_q     <= 1'b0;
            mem_addr_q   <= '0;
        end else if (rdy) begin
            case (state_q)
                IDLE: begin
                    resp_valid_q <= 1'b0;
                    if (accept) begin
                        if (hit) begin
                            resp_valid_q <= 1'b1;
                            resp_inst_q  <= hit_word;
                        end else begin
                            lat_widx_q   <= req_widx;
                            lat_idx_q    <= req_idx;
                            lat_tag_q    <= req_tag;
                            word_cnt_q   <= '0;
                            flush_seen_q <= 1'b0;
                            mem_rn_q     <= 1'b1;
                            mem_addr_q   <= req_base;
                            state_q      <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (bus.flush) begin
                        flush_seen_q <= 1'b1;
                    end
                    if (bus.mem_ready) begin
                        word_cnt_q <= word_cnt_q + 1'b1;
                        mem_addr_q <= mem_addr_q + ADDR_W'(4);
                        if (last_word) begin
                            mem_rn_q     <= 1'b0;
                            resp_valid_q <= 1'b1;
                            // The requested word may be the one arriving right now.
                            resp_inst_q  <= (word_cnt_q == lat_widx_q) ? bus.mem_value
                                                                       : lat_word;
                            state_q      <= RESP;
                        end
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_inst  = resp_inst_q;
    assign bus.mem_rn     = mem_rn_q;
    assign bus.mem_addr   = mem_addr_q;

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Performance counters: one count per accepted request, wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (accept) begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm (LINES=32, WORDS=4, ADDR_W=32): directed scenarios
// followed by random fetches against a line-level cache model.
`timescale 1ns/1ps
module tb_icache_dm;

    localparam int unsigned LINES  = 32;
    localparam int unsigned WORDS  = 4;
    localparam int unsigned ADDR_W = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    icache_dm_if #(.ADDR_W(ADDR_W)) bus ();

    icache_dm #(
        .LINES  (LINES),
        .WORDS  (WORDS),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .bus      (bus),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        int          due;   // monitor cycle a hit must appear in; -1 for misses
    } exp_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          rn_cycles = 0;
    exp_t        sb[$];
    logic [31:0] maddr_q[$];

    // Reference cache model: per index, is a line present and which tag.
    bit          mv[LINES];
    logic [22:0] mt[LINES];
    int          m_hits = 0;
    int          m_misses = 0;

    bit          mem_en = 1'b1;
    bit          late_pulse = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], ~a[31:16]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_cnt(input string tag);
`ifdef ICACHE_PERF_EN
        check({tag, "_hit_cnt"}, hit_cnt, m_hits);
        check({tag, "_miss_cnt"}, miss_cnt, m_misses);
`else
        check({tag, "_hit_cnt"}, hit_cnt, 0);
        check({tag, "_miss_cnt"}, miss_cnt, 0);
`endif
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
    endtask

    // Memory controller: answers the current mem_addr after a random gap, and holds
    // its pulse while rdy is low. Runs 2ns after each edge, after the main driver.
    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_value = '0;
        forever begin
            @(posedge clk);
            #2;
            if (!mem_en) begin
                bus.mem_ready = late_pulse;
                bus.mem_value = 32'hDEAD_BEEF;
            end else if (rdy) begin
                if (bus.mem_rn && !rst && ($urandom_range(0, 1) == 1)) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_value = memf(bus.mem_addr);
                end else begin
                    bus.mem_ready = 1'b0;
                end
            end
        end
    end

    // Monitor: response scoreboard and refill address sequence.
    initial begin
        exp_t e;
        logic [31:0] ea;
        forever begin
            @(negedge clk);
            if (bus.mem_rn) rn_cycles++;
            if (!rst && rdy && bus.mem_rn && bus.mem_ready) begin
                if (maddr_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL mem_addr_extra: got %h, expected no read", bus.mem_addr);
                end else begin
                    ea = maddr_q.pop_front();
                    check("mem_addr_seq", bus.mem_addr, ea);
                end
            end
            if (!rst && rdy && bus.resp_valid) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL resp_unexpected: got %h, expected no response",
                             bus.resp_inst);
                end else begin
                    e = sb.pop_front();
                    check("resp_inst", bus.resp_inst, e.inst);
                    if (e.due >= 0) check("hit_latency", cyc, e.due);
                end
            end
        end
    end

    // Present one request, wait (bounded) for acceptance, then update the model.
    task automatic fetch(input logic [31:0] a);
        bit          acc = 1'b0;
        int          idx;
        logic [22:0] tg;
        logic [31:0] base;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        for (int n = 0; n < 400 && !acc; n++) begin
            @(negedge clk);
            acc = bus.req_ready && rdy;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        if (!acc) begin
            total++; bad++;
            $display("FAIL fetch_timeout: addr %h not accepted, expected acceptance", a);
            return;
        end
        idx  = int'(a[8:4]);
        tg   = a[31:9];
        base = {a[31:4], 4'b0000};
        if (mv[idx] && mt[idx] == tg) begin
            m_hits++;
            sb.push_back('{inst: memf({a[31:2], 2'b00}), due: cyc});
            check("hit_no_mem_rn", bus.mem_rn, 0);
        end else begin
            m_misses++;
            mv[idx] = 1'b1;
            mt[idx] = tg;
            sb.push_back('{inst: memf({a[31:2], 2'b00}), due: -1});
            for (int k = 0; k < WORDS; k++) maddr_q.push_back(base + 32'(4 * k));
            check("miss_mem_rn", bus.mem_rn, 1);
            check("miss_line_base", bus.mem_addr, base);
        end
    endtask

    // Wait until every expected response has arrived and the cache is back in IDLE.
    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.mem_rn) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) begin
            total++; bad++;
            $display("FAIL drain_timeout: %0d responses pending, expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic flush_idle();
        drain();
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_blocks_ready", bus.req_ready, 0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        model_clear();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

    logic [22:0] tag_pool [4];
    int          rn0;
    logic [31:0] a0;
    logic [31:0] ra;

    initial begin
        tag_pool[0] = 23'h000000;
        tag_pool[1] = 23'h000001;
        tag_pool[2] = 23'h0002A5;
        tag_pool[3] = 23'h7FFFFF;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.flush     = 1'b0;
        model_clear();

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_inst", bus.resp_inst, 0);
        check("rst_mem_rn", bus.mem_rn, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check_cnt("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold miss, then three back-to-back hits in the same line.
        fetch(32'h0000_1234);
        drain();
        check_cnt("cold");
        rn0 = rn_cycles;
        fetch(32'h0000_1238);
        fetch(32'h0000_123C);
        fetch(32'h0000_1230);
        drain();
        check("hits_no_mem_rn", rn_cycles, rn0);
        check_cnt("hits");

        // Conflict on index 3.
        fetch(32'h0000_1434);
        drain();
        fetch(32'h0000_1234);
        drain();
        check_cnt("conflict");

        // Flush while idle, then refetch must miss.
        flush_idle();
        fetch(32'h0000_1234);
        drain();
        check_cnt("flush_idle");

        // Flush during a refill: response still delivered, line left invalid.
        fetch(32'h0000_2468);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        mv[6] = 1'b0;
        drain();
        fetch(32'h0000_2468);
        drain();
        check_cnt("flush_refill");

        // rdy low for three cycles after the first refill beat.
        fetch(32'h0000_3008);
        for (int n = 0; n < 200 && maddr_q.size() > 3; n++) begin
            @(posedge clk);
            #1;
        end
        a0 = bus.mem_addr;
        check("pause_addr", a0, 32'h0000_3004);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("pause_mem_addr", bus.mem_addr, a0);
            check("pause_mem_rn", bus.mem_rn, 1);
            check("pause_req_ready", bus.req_ready, 0);
            @(posedge clk);
            #1;
        end
        rdy = 1'b1;
        drain();
        check_cnt("pause");

        // Reset in the middle of a refill.
        fetch(32'h0000_4000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_req_ready", bus.req_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        maddr_q.delete();
        model_clear();
        m_hits = 0;
        m_misses = 0;
        check("rst_mid_mem_rn", bus.mem_rn, 0);
        check_cnt("rst_mid");
        mem_en = 1'b0;
        late_pulse = 1'b1;
        @(posedge clk);
        #1;
        late_pulse = 1'b0;
        check("late_pulse_mem_rn", bus.mem_rn, 0);
        check("late_pulse_resp", bus.resp_valid, 0);
        @(posedge clk);
        #1;
        mem_en = 1'b1;
        fetch(32'h0000_4000);
        drain();
        check_cnt("after_rst");

        // Random fetches over a small tag pool, with occasional flushes and gaps.
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 11))
                0: flush_idle();
                1: begin
                    @(posedge clk);
                    #1;
                end
                default: begin
                    ra = {tag_pool[$urandom_range(0, 3)], 5'($urandom_range(0, 31)),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
                    fetch(ra);
                end
            endcase
        end
        drain();
        check_cnt("random");
        check("random_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_dm.md
# icache_dm

Parametrised direct-mapped instruction cache between the fetch stage and the memory controller's instruction read port. It serves aligned 32-bit instruction fetches in one cycle on a hit. On a miss it refills a whole line through a one-word-per-pulse memory handshake. Line count, line length and address width are configurable, and the cache supports a single-cycle flush and optional hit/miss counters.

## Interface
- LINES, default 32: number of cache lines; power of 2, ≥2.
- WORDS, default 4: 32-bit words per line; power of 2, ≥2.
- ADDR_W, default 32: fetch/memory address width.
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- rdy  in  1  global ready. When low, all state, outputs and counters hold.
- req_valid  in  1  fetch request.
- req_addr  in  ADDR_W  fetch byte address; bits [1:0] are ignored.
- req_ready  out  1  request accepted when req_valid & req_ready & rdy.
- resp_valid  out  1  one-cycle pulse; resp_inst is valid.
- resp_inst  out  32  fetched instruction.
- flush  in  1  invalidate all lines.
- mem_rn  out  1  memory read request, held high for the whole refill.
- mem_addr  out  ADDR_W  word address being read.
- mem_ready  in  1  one-cycle pulse; mem_value is valid for mem_addr.
- mem_value  in  32  memory read data.
- hit_cnt  out  32  hits counted since reset.
- miss_cnt  out  32  misses counted since reset.

## Operation
- Address split, from LSB: 2 byte bits, log2(WORDS) word bits, log2(LINES) index bits, remaining bits are tag.
- Storage: data array, tag array and one valid bit per line. Valid bits are flops; all valid bits clear on rst.
- FSM states:
  - IDLE: req_ready = !flush.
  - REFILL
  - RESP
- IDLE, request accepted:
  - Hit (valid[idx] & tag match): resp_inst ← word, resp_valid=1 next cycle; stay in IDLE.
  - Miss: latch address; mem_addr ← line base (word and byte bits zeroed); mem_rn=1; go to REFILL.
- REFILL:
  - On each mem_ready: write mem_value to word k, k++, mem_addr += 4.
  - On the last word (k = WORDS-1): write the tag, set valid unless a flush was seen during the refill, mem_rn=0, go to RESP.
- RESP: resp_valid=1, resp_inst = requested word (from the latched address); go to IDLE.
- flush:
  - In IDLE, clears every valid bit that cycle and blocks acceptance (req_ready=0).
  - In REFILL or RESP, marks the in-flight line non-valid on completion. The pending response is still delivered.
- mem_ready while not in REFILL is ignored.
- rst mid-refill: return to IDLE, mem_rn=0, valid bits cleared. Any late mem_ready is ignored.
- Request address wrap at 2^ADDR_W needs no special handling; line base arithmetic is modulo 2^ADDR_W.

## Timing
- Reset values:
  - req_ready=0 while rst is high.
  - resp_valid=0, resp_inst=0, mem_rn=0, mem_addr=0, hit_cnt=0, miss_cnt=0; state IDLE.
- Hit latency: resp_valid one cycle after acceptance. Back-to-back hits give 1 fetch/cycle.
- Miss latency: mem_rn rises the cycle after acceptance. resp_valid comes one cycle after the WORDS-th mem_ready. Total = 1 + (memory cycles) + 1.
- req_ready is 0 from the miss-accept cycle+1 through RESP inclusive.
- All outputs are registered except req_ready, which is combinational from state, flush and rst.
- rdy low: nothing updates. The memory controller is gated by the same rdy, so no mem_ready pulse is lost.

## Configuration
- ICACHE_PERF_EN defined:
  - hit_cnt increments per accepted hit.
  - miss_cnt increments per accepted miss.
  - Both wrap modulo 2^32 and are cleared only by rst.
- ICACHE_PERF_EN undefined: the ports remain and are tied to 0; no counter flops are synthesised.

## Structure
- icache_pkg holds:
  - state enum (IDLE, REFILL, RESP).
  - width constants/functions: OFF_W=2, WIDX_W=$clog2(WORDS), IDX_W=$clog2(LINES), TAG_W=ADDR_W-IDX_W-WIDX_W-2.
- One sub-module, icache_tag_array: valid + tag storage, flush clear, hit compare.
- Data array, FSM and counters stay in icache_dm.

## Test plan
Defaults for all scenarios: LINES=32, WORDS=4, ICACHE_PERF_EN defined.
- Cold miss, fetch 0x1234:
  - mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C.
  - resp_inst = value returned for 0x1234.
  - miss_cnt=1.
- Then fetch 0x1238, 0x123C, 0x1230 on consecutive cycles: three resp_valid pulses on consecutive cycles, mem_rn stays 0, hit_cnt=3.
- Conflict: fetch 0x1234, then 0x1434 (same index 3, different tag) → refill at 0x1430. Then fetch 0x1234 → miss again.
- Flush:
  - flush in IDLE, then fetch 0x1234 → miss.
  - flush asserted during a refill → response still delivered, and an immediate refetch of that address misses.
- Pauses and reset: rdy held low for 3 cycles mid-refill → mem_addr/state frozen, refill completes correctly. rst mid-refill → mem_rn=0 next cycle, a later mem_ready has no effect, counters=0.
